// File: rtl/scroll_arbiter.sv
// -----------------------------------------------------------------------------
// scroll_arbiter
//
// Purpose:
//   Shares one 2-bit HEX scroll position between two button-pair requesters.
//   Key presses are edge detected, each requester holds one pending step
//   (latest press wins), steps are granted round-robin, and every grant is
//   followed by a programmable cooldown during which no further step is
//   applied. The block owns the position register.
//
// Build option:
//   SCROLL_WRAP_EN  defined   -> position wraps (3 -> 0 right, 0 -> 3 left)
//                   undefined -> position saturates at 0 and 3 (default)
//
// Parameters:
//   COOLDOWN  idle cycles after each grant before the next grant (0..15)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   l0, r0    in   requester 0 left/right keys (synchronized levels)
//   l1, r1    in   requester 1 left/right keys (synchronized levels)
//   pos       out  current scroll position 0..3 (registered)
//   grant     out  one-hot, one-cycle pulse naming the granted requester
//   step      out  one-cycle pulse coincident with any grant bit
//   step_dir  out  direction of the granted step (1 = right), 0 when idle
//   busy      out  high while the cooldown is running
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module scroll_arbiter #(
  parameter int unsigned COOLDOWN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       l0,
  input  logic       r0,
  input  logic       l1,
  input  logic       r1,
  output logic [1:0] pos,
  output logic [1:0] grant,
  output logic       step,
  output logic       step_dir,
  output logic       busy
);

  localparam logic [3:0] CD = 4'(COOLDOWN);

  typedef enum logic {ST_IDLE, ST_COOL} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_rr;
  logic [1:0] r_pos;
  logic [1:0] r_grant;
  logic       r_step;
  logic       r_step_dir;
  logic       r_busy;

  logic [1:0] r_prev_l;
  logic [1:0] r_prev_r;
  logic [1:0] r_pend_vld;
  logic [1:0] r_pend_dir;

  logic [1:0] w_key_l;
  logic [1:0] w_key_r;
  logic [1:0] w_rise_l;
  logic [1:0] w_rise_r;
  logic [1:0] w_req_vld;
  logic [1:0] w_req_dir;
  logic [1:0] w_pend_vld_next;
  logic [1:0] w_pend_dir_next;

  logic       w_do_grant;
  logic       w_win_idx;
  logic       w_win_dir;
  logic [1:0] w_win_oh;
  logic [1:0] w_pos_next;

  assign w_key_l = {l1, l0};
  assign w_key_r = {r1, r0};

  // Per-requester edge detect, request decode and pending-slot update.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign w_rise_l[gi]  = w_key_l[gi] & ~r_prev_l[gi];
      assign w_rise_r[gi]  = w_key_r[gi] & ~r_prev_r[gi];
      // Both keys rising together cancel out: only a lone edge is a request.
      assign w_req_vld[gi] = w_rise_l[gi] ^ w_rise_r[gi];
      assign w_req_dir[gi] = w_rise_r[gi];
      // A grant clears the slot, but a request on the same edge re-arms it.
      assign w_pend_vld_next[gi] = w_req_vld[gi] | (r_pend_vld[gi] & ~w_win_oh[gi]);
      assign w_pend_dir_next[gi] = w_req_vld[gi] ? w_req_dir[gi] : r_pend_dir[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_l   <= '0;
      r_prev_r   <= '0;
      r_pend_vld <= '0;
      r_pend_dir <= '0;
    end else begin
      r_prev_l   <= w_key_l;
      r_prev_r   <= w_key_r;
      r_pend_vld <= w_pend_vld_next;
      r_pend_dir <= w_pend_dir_next;
    end
  end

  // Grant decision: the round-robin favourite wins if it has a step pending.
  always_comb begin
    w_do_grant = (r_state == ST_IDLE) && (|r_pend_vld);
    w_win_idx  = r_pend_vld[r_rr] ? r_rr : ~r_rr;
    w_win_dir  = r_pend_dir[w_win_idx];
    w_win_oh   = '0;
    if (w_do_grant) begin
      w_win_oh[w_win_idx] = 1'b1;
    end
  end

  // Position after applying the winning step.
  always_comb begin
`ifdef SCROLL_WRAP_EN
    w_pos_next = w_win_dir ? (r_pos + 2'd1) : (r_pos - 2'd1);
`else
    if (w_win_dir) begin
      w_pos_next = (r_pos == 2'd3) ? r_pos : (r_pos + 2'd1);
    end else begin
      w_pos_next = (r_pos == 2'd0) ? r_pos : (r_pos - 2'd1);
    end
`endif
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rr       <= 1'b0;
      r_pos      <= '0;
      r_grant    <= '0;
      r_step     <= 1'b0;
      r_step_dir <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_grant    <= w_win_oh;
      r_step     <= w_do_grant;
      r_step_dir <= w_do_grant & w_win_dir;
      case (r_state)
        ST_IDLE: begin
          if (w_do_grant) begin
            r_pos <= w_pos_next;
            r_rr  <= ~w_win_idx;
            r_cnt <= CD;
            if (CD != 4'd0) begin
              r_state <= ST_COOL;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_COOL: begin
          r_cnt <= r_cnt - 4'd1;
          // Counter reaches zero on this edge: the next edge may grant.
          if (r_cnt <= 4'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pos      = r_pos;
  assign grant    = r_grant;
  assign step     = r_step;
  assign step_dir = r_step_dir;
  assign busy     = r_busy;

endmodule

// File: tb/tb_scroll_arbiter.sv
`timescale 1ns/1ps

module tb_scroll_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       l0 = 1'b0, r0 = 1'b0, l1 = 1'b0, r1 = 1'b0;
  logic [1:0] pos, grant;
  logic       step, step_dir, busy;

  logic       z_l0 = 1'b0, z_r0 = 1'b0, z_l1 = 1'b0, z_r1 = 1'b0;
  logic [1:0] z_pos, z_grant;
  logic       z_step, z_step_dir, z_busy;

  int checks = 0;
  int errors = 0;

  // Observed output bundle: {pos[1:0], grant[1:0], step, step_dir, busy}
  logic [6:0] obs;
  logic [6:0] z_obs;
  assign obs   = {pos, grant, step, step_dir, busy};
  assign z_obs = {z_pos, z_grant, z_step, z_step_dir, z_busy};

  always #5 clk = ~clk;

  scroll_arbiter #(.COOLDOWN(4)) u_dut (
    .clk(clk), .reset(rst),
    .l0(l0), .r0(r0), .l1(l1), .r1(r1),
    .pos(pos), .grant(grant), .step(step), .step_dir(step_dir), .busy(busy)
  );

  scroll_arbiter #(.COOLDOWN(0)) u_dut0 (
    .clk(clk), .reset(rst),
    .l0(z_l0), .r0(z_r0), .l1(z_l1), .r1(z_r1),
    .pos(z_pos), .grant(z_grant), .step(z_step), .step_dir(z_step_dir), .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    {l1, r1, l0, r0} = 4'b0;
    {z_l1, z_r1, z_l0, z_r0} = 4'b0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // keys = {l1, r1, l0, r0}, held for exactly one sampling edge
  task automatic press(input logic [3:0] keys);
    $display("t=%0t press {l1,r1,l0,r0}=%b", $time, keys);
    {l1, r1, l0, r0} = keys;
    tick();
    {l1, r1, l0, r0} = 4'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b00_00_0_0_0) begin
      errors++;
      $display("FAIL reset_async got %b required %b", obs, 7'b0);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if ({obs, z_obs} !== 14'b0) begin
      errors++;
      $display("FAIL reset_release got %b/%b required 0/0", obs, z_obs);
    end
  endtask

  task automatic test_single();
    int busy_cnt;
    int step_cnt;
    press(4'b0001);
    checks++;
    if (obs !== 7'b00_00_0_0_0) begin
      errors++;
      $display("FAIL single_pending got %b required %b", obs, 7'b00_00_0_0_0);
    end
    tick();
    checks++;
    if (obs !== 7'b01_01_1_1_1) begin
      errors++;
      $display("FAIL single_grant got %b required %b", obs, 7'b01_01_1_1_1);
    end
    busy_cnt = 1;
    step_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      busy_cnt += int'(busy);
      step_cnt += int'(step);
    end
    checks++;
    if (busy_cnt != 4 || step_cnt != 0 || pos !== 2'd1) begin
      errors++;
      $display("FAIL single_busy got busy=%0d steps=%0d pos=%0d required busy=4 steps=0 pos=1",
               busy_cnt, step_cnt, pos);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_pos [4];
    exp_pos[0] = 2'd1;
    exp_pos[1] = 2'd2;
    exp_pos[2] = 2'd3;
`ifdef SCROLL_WRAP_EN
    exp_pos[3] = 2'd0;
`else
    exp_pos[3] = 2'd3;
`endif
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      press(4'b0001);
      tick();
      checks++;
      if (obs !== {exp_pos[k], 2'b01, 1'b1, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL saturate_%0d got %b required %b", k, obs,
                 {exp_pos[k], 2'b01, 1'b1, 1'b1, 1'b1});
      end
      repeat (6) tick();
    end
  endtask

  task automatic test_contention();
    apply_reset();
    press(4'b1001);                       // r0 and l1 together
    tick();
    checks++;
    if (obs !== 7'b01_01_1_1_1) begin
      errors++;
      $display("FAIL contend_first got %b required %b", obs, 7'b01_01_1_1_1);
    end
    repeat (3) tick();
    checks++;
    if (obs !== 7'b01_00_0_0_1) begin
      errors++;
      $display("FAIL contend_cool got %b required %b", obs, 7'b01_00_0_0_1);
    end
    tick();
    checks++;
    if (obs !== 7'b01_00_0_0_0) begin
      errors++;
      $display("FAIL contend_gap got %b required %b", obs, 7'b01_00_0_0_0);
    end
    tick();
    checks++;
    if (obs !== 7'b00_10_1_0_1) begin
      errors++;
      $display("FAIL contend_second got %b required %b", obs, 7'b00_10_1_0_1);
    end
    repeat (5) tick();
    press(4'b0001);                       // lone r0 leaves rr pointing at requester 1
    tick();
    checks++;
    if (obs !== 7'b01_01_1_1_1) begin
      errors++;
      $display("FAIL contend_solo got %b required %b", obs, 7'b01_01_1_1_1);
    end
    repeat (5) tick();
    press(4'b1001);
    tick();
    checks++;
    if (obs !== 7'b00_10_1_0_1) begin
      errors++;
      $display("FAIL contend_rr_first got %b required %b", obs, 7'b00_10_1_0_1);
    end
    repeat (5) tick();
    checks++;
    if (obs !== 7'b01_01_1_1_1) begin
      errors++;
      $display("FAIL contend_rr_second got %b required %b", obs, 7'b01_01_1_1_1);
    end
    repeat (5) tick();
  endtask

  task automatic test_both_keys();
    apply_reset();
    press(4'b0011);                       // l0 and r0 together
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 7'b00_00_0_0_0) begin
        errors++;
        $display("FAIL both_keys_%0d got %b required %b", i, obs, 7'b0);
      end
    end
  endtask

  task automatic test_overwrite_in_cool();
    int step_cnt;
    apply_reset();
    press(4'b0100);                       // r1 starts a cooldown
    tick();
    checks++;
    if (obs !== 7'b01_10_1_1_1) begin
      errors++;
      $display("FAIL ovr_setup got %b required %b", obs, 7'b01_10_1_1_1);
    end
    r0 = 1'b1;
    tick();
    r0 = 1'b0;
    l0 = 1'b1;
    tick();
    l0 = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 7'b01_00_0_0_0) begin
      errors++;
      $display("FAIL ovr_wait got %b required %b", obs, 7'b01_00_0_0_0);
    end
    tick();
    checks++;
    if (obs !== 7'b00_01_1_0_1) begin
      errors++;
      $display("FAIL ovr_grant got %b required %b", obs, 7'b00_01_1_0_1);
    end
    step_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      step_cnt += int'(step);
    end
    checks++;
    if (step_cnt != 0 || pos !== 2'd0) begin
      errors++;
      $display("FAIL ovr_single got steps=%0d pos=%0d required steps=0 pos=0", step_cnt, pos);
    end
  endtask

  task automatic test_reset_mid_cool();
    int step_cnt;
    apply_reset();
    press(4'b0001);
    tick();
    checks++;
    if (obs !== 7'b01_01_1_1_1) begin
      errors++;
      $display("FAIL rmc_grant got %b required %b", obs, 7'b01_01_1_1_1);
    end
    press(4'b0100);                       // requester 1 pending during COOL
    tick();
    checks++;
    if (obs !== 7'b01_00_0_0_1) begin
      errors++;
      $display("FAIL rmc_cool got %b required %b", obs, 7'b01_00_0_0_1);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b00_00_0_0_0) begin
      errors++;
      $display("FAIL rmc_async got %b required %b", obs, 7'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    step_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      step_cnt += int'(step);
    end
    checks++;
    if (step_cnt != 0 || obs !== 7'b00_00_0_0_0) begin
      errors++;
      $display("FAIL rmc_after got steps=%0d obs=%b required steps=0 obs=%b", step_cnt, obs, 7'b0);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    apply_reset();
    $display("t=%0t press (COOLDOWN=0) r0+r1", $time);
    z_r0 = 1'b1;
    z_r1 = 1'b1;
    tick();
    z_r0 = 1'b0;
    z_r1 = 1'b0;
    busy_cnt = int'(z_busy);
    tick();
    busy_cnt += int'(z_busy);
    checks++;
    if (z_obs !== 7'b01_01_1_1_0) begin
      errors++;
      $display("FAIL b2b_first got %b required %b", z_obs, 7'b01_01_1_1_0);
    end
    tick();
    busy_cnt += int'(z_busy);
    checks++;
    if (z_obs !== 7'b10_10_1_1_0) begin
      errors++;
      $display("FAIL b2b_second got %b required %b", z_obs, 7'b10_10_1_1_0);
    end
    tick();
    busy_cnt += int'(z_busy);
    checks++;
    if (z_obs !== 7'b10_00_0_0_0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL b2b_idle got %b busy=%0d required %b busy=0", z_obs, busy_cnt, 7'b10_00_0_0_0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_contention();
    test_both_keys();
    test_overwrite_in_cool();
    test_reset_mid_cool();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scroll_arbiter.md
# scroll_arbiter

Shares a single 2-bit scroll position between two button-pair requesters (player 0, player 1) on the HEX display board. Each requester presses left/right keys; the block edge-detects the presses, holds one pending step per requester, grants steps round-robin with a programmable cooldown between grants, and owns the saturating position register that drives the HEX scroll. It sits between the synchronized key inputs and the display decode logic.

## Interface

- COOLDOWN, default 4: idle cycles enforced after each grant before the next grant; range 0..15.
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- l0  input  1  requester 0 left key (level, already synchronized to clk).
- r0  input  1  requester 0 right key.
- l1  input  1  requester 1 left key.
- r1  input  1  requester 1 right key.
- pos  output  2  current scroll position 0..3, registered.
- grant  output  2  one-hot, one-cycle pulse: bit i = requester i's step was applied this cycle.
- step  output  1  one-cycle pulse coincident with any grant bit.
- step_dir  output  1  direction of the granted step (1 = right, 0 = left); 0 when step=0.
- busy  output  1  high while in COOL.

## Operation

- Edge detect: per key, prev register (reset 0); rise = key & ~prev.
- Decode per requester: rise_r only -> right request; rise_l only -> left request; both or neither -> no request.
- Pending slot per requester: valid + dir. New request overwrites existing pending (latest press wins, direction replaced).
- Round-robin pointer rr (reset 0 = requester 0 has priority). After a grant to i, rr <= other requester.
- FSM states IDLE, COOL:
  - IDLE: if any pending valid, grant to requester rr if its slot is valid, else to the other; clear winner's slot; apply step; load cooldown counter with COOLDOWN; go COOL if COOLDOWN>0, else remain IDLE. Loser's slot remains pending.
  - COOL: counter decrements each cycle; no grants; on counter reaching 0 return to IDLE. Pending slots still capture/overwrite.
- Request arriving on the same edge its slot is granted: slot is cleared by the grant and then set by the new request (new one stays pending).
- Step arithmetic: right: pos==3 ? 3 : pos+1; left: pos==0 ? 0 : pos-1. A saturated step still pulses grant/step with pos unchanged.

## Timing

- Reset (async): pos=0, grant=00, step=0, step_dir=0, busy=0, state IDLE, rr=0, pending cleared, counter 0, prev regs 0. Reset mid-COOL abandons cooldown and pending requests.
- Key high first sampled at edge E -> pending set at E; grant decided from pending at E+1; grant/step/step_dir/pos updated after E+1 (2-edge latency, no contention).
- Grant at edge G: next grant earliest at edge G+COOLDOWN+1. busy high for cycles G+1 .. G+COOLDOWN.
- COOLDOWN=0: back-to-back grants every cycle; busy never asserts.
- Held keys generate exactly one request (edge only); re-press requires key low for ≥1 sampled edge.

## Configuration

- SCROLL_WRAP_EN defined: position wraps: right from 3 -> 0, left from 0 -> 3.
- SCROLL_WRAP_EN undefined: position saturates at 0 and 3 as in Operation.
- All other behaviour (grant, timing, busy) identical in both builds.

## Test plan

- Reset, then r0 pulse 1 cycle -> two edges later grant=01, step=1, step_dir=1, pos=1 for one cycle pulse; busy high 4 cycles (COOLDOWN=4).
- Four r0 presses spaced 8 cycles -> pos 1,2,3,3; fourth grant still pulses; with SCROLL_WRAP_EN pos 1,2,3,0.
- r0 and l1 rise same cycle after reset -> grant=01 pos=1, then grant=10 exactly 5 cycles later pos=0; next simultaneous pair grants requester 1 first (rr rotated).
- l0 and r0 rise same cycle -> no pending, no grant, pos unchanged.
- During COOL, r0 press then l0 press -> single grant=01 after cooldown with step_dir=0, pos decrements once.
- Assert reset during COOL with requester 1 pending -> all outputs 0 immediately (before next clk); after release no grant occurs without new presses.
